pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage ARM core.
- Generates freeze/flush controls for PC, IF/ID, ID/EX (flush-before-freeze register), EX/MEM and MEM/WB from three sources, in priority order: multi-cycle data-memory wait, taken branch, RAW hazard.
- Holds a wait-state FSM and saturating stall/flush performance counters.

Parameters:
- MEM_WAIT, 3: stall cycles added per data-memory access (0 = single-cycle memory, no stall).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- src1  in  4  ID-stage Rn index.
- src2  in  4  ID-stage Rm/Rd index (second source).
- one_src  in  1  src1 is read by the ID instruction.
- two_src  in  1  src2 is read by the ID instruction.
- forward_en  in  1  forwarding unit enabled.
- ex_dest  in  4  EX-stage destination register.
- ex_wb_en  in  1  EX-stage writes back.
- ex_mem_r_en  in  1  EX-stage instruction is a load.
- mem_dest  in  4  MEM-stage destination register.
- mem_wb_en  in  1  MEM-stage writes back.
- mem_req  in  1  MEM-stage read or write access.
- branch_taken  in  1  EX-stage branch resolved taken.
- cnt_clr  in  1  synchronous clear of both counters.
- freeze_if  out  1  hold PC and IF/ID register.
- flush_if  out  1  clear IF/ID register.
- freeze_id  out  1  hold ID/EX register.
- flush_id  out  1  clear ID/EX register (insert bubble).
- freeze_mem  out  1  hold EX/MEM and MEM/WB registers.
- mem_stall  out  1  memory wait in progress.
- hazard  out  1  raw hazard detect, before masking.
- stall_cnt  out  CNT_W  cycles with freeze_if=1.
- flush_cnt  out  CNT_W  accepted branch flushes.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, wcnt=0, stall_cnt=0, flush_cnt=0. All control outputs forced 0 while rst=1.
- Wait FSM states:
  - IDLE: if mem_req and MEM_WAIT>0 then mem_stall=1, wcnt<=MEM_WAIT-1, next state WAIT. Otherwise mem_stall=0.
  - WAIT: mem_stall=(wcnt!=0). If wcnt!=0 then wcnt<=wcnt-1; else next state IDLE.
  - Result: each access occupies MEM exactly MEM_WAIT+1 cycles.
  - mem_req is not re-sampled in WAIT. A new access in MEM on the cycle after release is sampled in IDLE. Back-to-back accesses therefore give a stall pattern of 1,1,1,0,1,1,1,0 for MEM_WAIT=3.
- hazard (combinational):
  - forward_en=0: a match is (one_src & src1==X) | (two_src & src2==X). hazard = match on X=ex_dest with ex_wb_en, OR match on X=mem_dest with mem_wb_en.
  - forward_en=1: hazard = match on X=ex_dest with ex_wb_en & ex_mem_r_en (load-use only).
- Output priority, with mem_stall highest:
  - freeze_mem = mem_stall.
  - freeze_id = mem_stall.
  - flush_if = branch_taken & ~mem_stall.
  - flush_id = ~mem_stall & (branch_taken | hazard).
  - freeze_if = mem_stall | (hazard & ~branch_taken).
- flush_id and freeze_id are never both 1, so the ID/EX flush-first ordering never drops a frozen instruction.
- Branch together with hazard: the branch wins. PC loads the target, IF/ID and ID/EX are both flushed, and the hazard is discarded.
- Counters:
  - stall_cnt += 1 on each cycle with freeze_if=1.
  - flush_cnt += 1 on each cycle with flush_if=1.
  - Both saturate at all-ones and never wrap.
  - cnt_clr has priority over increment: the clear takes effect at the next edge and that cycle's event is not counted.
- Reset mid-WAIT: FSM returns to IDLE immediately and mem_stall drops asynchronously.

Test Plan:
- MEM_WAIT=3, single mem_req pulse held while stalled → mem_stall=1 for 3 cycles then 0; freeze_id=freeze_mem=freeze_if=1 for those cycles; flush_id=0 throughout; stall_cnt=3.
- forward_en=1, ex_mem_r_en=1, ex_wb_en=1, ex_dest=4, src1=4, one_src=1 → hazard=1, freeze_if=1, flush_id=1, freeze_id=0. Same case with ex_mem_r_en=0 → hazard=0.
- forward_en=0, mem_wb_en=1, mem_dest=7, src2=7, two_src=1, one_src=0 → hazard=1. Same case with two_src=0 → hazard=0.
- branch_taken=1 with a simultaneous hazard → flush_if=1, flush_id=1, freeze_if=0; flush_cnt increments by 1.
- branch_taken=1 while FSM in WAIT with wcnt=2 → flush_if=flush_id=0 until the release cycle, then flush_if=1 on that cycle if branch_taken is still held.
- Drive freeze_if=1 for 2^CNT_W+5 cycles → stall_cnt=all-ones. Then cnt_clr for 1 cycle → stall_cnt=0 at the next edge. Assert rst mid-WAIT → mem_stall=0 immediately and counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: merges memory wait, taken branch and
// RAW hazard into stage freeze/flush controls, plus stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int MEM_WAIT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             one_src,
  input  logic             two_src,
  input  logic             forward_en,
  input  logic [3:0]       ex_dest,
  input  logic             ex_wb_en,
  input  logic             ex_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_req,
  input  logic             branch_taken,
  input  logic             cnt_clr,
  output logic             freeze_if,
  output logic             flush_if,
  output logic             freeze_id,
  output logic             flush_id,
  output logic             freeze_mem,
  output logic             mem_stall,
  output logic             hazard,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = (MEM_WAIT > 2) ? $clog2(MEM_WAIT) : 1;
  localparam bit HAS_WAIT = (MEM_WAIT > 0);
  localparam logic [WC_W-1:0] WAIT_LOAD = WC_W'((MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t          state;
  logic [WC_W-1:0] wcnt;
  logic            stall_raw;
  logic            hazard_raw;

  function automatic logic src_match(input logic [3:0] x, input logic [3:0] s1,
                                     input logic [3:0] s2, input logic u1, input logic u2);
    return (u1 & (s1 == x)) | (u2 & (s2 == x));
  endfunction

  // Wait-state sequencer; mem_req is only sampled in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req && HAS_WAIT) begin
            wcnt  <= WAIT_LOAD;
            state <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wcnt != '0) begin
            wcnt <= wcnt - WC_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          wcnt  <= '0;
        end
      endcase
    end
  end

  // Memory stall request and raw hazard detection.
  always_comb begin
    stall_raw = 1'b0;
    case (state)
      IDLE:    stall_raw = mem_req & HAS_WAIT;
      WAIT:    stall_raw = (wcnt != '0);
      default: stall_raw = 1'b0;
    endcase
    if (forward_en) begin
      hazard_raw = ex_wb_en & ex_mem_r_en & src_match(ex_dest, src1, src2, one_src, two_src);
    end else begin
      hazard_raw = (ex_wb_en & src_match(ex_dest, src1, src2, one_src, two_src)) |
                   (mem_wb_en & src_match(mem_dest, src1, src2, one_src, two_src));
    end
  end

  // Priority merge: memory stall, then branch, then hazard; all low during reset.
  always_comb begin
    if (rst) begin
      mem_stall  = 1'b0;
      hazard     = 1'b0;
      freeze_mem = 1'b0;
      freeze_id  = 1'b0;
      flush_if   = 1'b0;
      flush_id   = 1'b0;
      freeze_if  = 1'b0;
    end else begin
      mem_stall  = stall_raw;
      hazard     = hazard_raw;
      freeze_mem = stall_raw;
      freeze_id  = stall_raw;
      flush_if   = branch_taken & ~stall_raw;
      flush_id   = ~stall_raw & (branch_taken | hazard_raw);
      freeze_if  = stall_raw | (hazard_raw & ~branch_taken);
    end
  end

  // Saturating count of frozen-fetch cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (freeze_if && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

  // Saturating count of accepted branch flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      flush_cnt <= '0;
    end else if (flush_if && (flush_cnt != '1)) begin
      flush_cnt <= flush_cnt + CNT_W'(1);
    end else begin
      flush_cnt <= flush_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_WAIT=3, CNT_W=16).
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] src1, src2, ex_dest, mem_dest;
  logic one_src, two_src, forward_en, ex_wb_en, ex_mem_r_en, mem_wb_en;
  logic mem_req, branch_taken, cnt_clr;
  logic freeze_if, flush_if, freeze_id, flush_id, freeze_mem, mem_stall, hazard;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.MEM_WAIT(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .one_src(one_src), .two_src(two_src),
    .forward_en(forward_en), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .branch_taken(branch_taken),
    .cnt_clr(cnt_clr), .freeze_if(freeze_if), .flush_if(flush_if), .freeze_id(freeze_id),
    .flush_id(flush_id), .freeze_mem(freeze_mem), .mem_stall(mem_stall), .hazard(hazard),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    src1 = 4'd0; src2 = 4'd0; one_src = 1'b0; two_src = 1'b0; forward_en = 1'b0;
    ex_dest = 4'd0; ex_wb_en = 1'b0; ex_mem_r_en = 1'b0; mem_dest = 4'd0; mem_wb_en = 1'b0;
    mem_req = 1'b0; branch_taken = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; mem_req = 1'b1; branch_taken = 1'b1;
    ex_wb_en = 1'b1; ex_dest = 4'd2; src1 = 4'd2; one_src = 1'b1;
    @(negedge clk);
    checks++; if ({freeze_if, flush_if, freeze_id, flush_id, freeze_mem, mem_stall} !== 6'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 000000", {freeze_if, flush_if, freeze_id, flush_id, freeze_mem, mem_stall}); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
    checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_flush_cnt got %0d exp 0", flush_cnt); end
    idle_inputs();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_mem_wait();
    logic exp;
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_req = 1'b0;
      @(negedge clk);
      exp = (i < 3);
      checks++; if (mem_stall !== exp) begin errors++; $display("FAIL wait_mem_stall[%0d] got %b exp %b", i, mem_stall, exp); end
      checks++; if ({freeze_if, freeze_id, freeze_mem} !== {3{exp}}) begin errors++; $display("FAIL wait_freeze[%0d] got %b exp %b", i, {freeze_if, freeze_id, freeze_mem}, {3{exp}}); end
      checks++; if (flush_id !== 1'b0) begin errors++; $display("FAIL wait_flush_id[%0d] got %b exp 0", i, flush_id); end
      step();
    end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL wait_stall_cnt got %0d exp 3", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat;
    pat = 8'b1110_1110;
    mem_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (mem_stall !== pat[7-i]) begin errors++; $display("FAIL b2b_mem_stall[%0d] got %b exp %b", i, mem_stall, pat[7-i]); end
      step();
    end
    mem_req = 1'b0;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", mem_stall); end
    checks++; if (stall_cnt !== 16'd9) begin errors++; $display("FAIL b2b_stall_cnt got %0d exp 9", stall_cnt); end
    step();
  endtask

  task automatic test_load_use();
    idle_inputs();
    forward_en = 1'b1; ex_mem_r_en = 1'b1; ex_wb_en = 1'b1; ex_dest = 4'd4; src1 = 4'd4; one_src = 1'b1;
    @(negedge clk);
    checks++; if ({hazard, freeze_if, flush_id, freeze_id, flush_if} !== 5'b11100) begin errors++; $display("FAIL load_use got %b exp 11100", {hazard, freeze_if, flush_id, freeze_id, flush_if}); end
    ex_mem_r_en = 1'b0;
    #1;
    checks++; if ({hazard, freeze_if, flush_id} !== 3'b000) begin errors++; $display("FAIL fwd_no_load got %b exp 000", {hazard, freeze_if, flush_id}); end
    idle_inputs();
    step();
  endtask

  task automatic test_raw_nofwd();
    idle_inputs();
    mem_wb_en = 1'b1; mem_dest = 4'd7; src2 = 4'd7; two_src = 1'b1;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL raw_mem_src2 got %b exp 1", hazard); end
    two_src = 1'b0;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL raw_src2_unused got %b exp 0", hazard); end
    two_src = 1'b1; forward_en = 1'b1;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL raw_mem_forwarded got %b exp 0", hazard); end
    idle_inputs();
    ex_wb_en = 1'b1; ex_dest = 4'd3; src1 = 4'd3; one_src = 1'b1; src2 = 4'd5; two_src = 1'b1;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL raw_ex_src1 got %b exp 1", hazard); end
    ex_dest = 4'd6;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL raw_ex_nomatch got %b exp 0", hazard); end
    idle_inputs();
    step();
  endtask

  task automatic test_branch();
    idle_inputs();
    forward_en = 1'b1; ex_mem_r_en = 1'b1; ex_wb_en = 1'b1; ex_dest = 4'd9; src1 = 4'd9; one_src = 1'b1;
    branch_taken = 1'b1;
    @(negedge clk);
    checks++; if ({flush_if, flush_id, freeze_if, freeze_id} !== 4'b1100) begin errors++; $display("FAIL branch_hazard got %b exp 1100", {flush_if, flush_id, freeze_if, freeze_id}); end
    step();
    idle_inputs();
    checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL branch_flush_cnt got %0d exp 1", flush_cnt); end
    checks++; if (stall_cnt !== 16'd9) begin errors++; $display("FAIL branch_stall_cnt got %0d exp 9", stall_cnt); end
  endtask

  task automatic test_branch_in_wait();
    logic exp;
    mem_req = 1'b1; branch_taken = 1'b1;
    step();
    mem_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = (i == 2);
      @(negedge clk);
      checks++; if ({flush_if, flush_id} !== {2{exp}}) begin errors++; $display("FAIL branch_wait[%0d] got %b exp %b", i, {flush_if, flush_id}, {2{exp}}); end
      step();
    end
    branch_taken = 1'b0;
    checks++; if (flush_cnt !== 16'd2) begin errors++; $display("FAIL branch_wait_flush_cnt got %0d exp 2", flush_cnt); end
    checks++; if (stall_cnt !== 16'd12) begin errors++; $display("FAIL branch_wait_stall_cnt got %0d exp 12", stall_cnt); end
  endtask

  task automatic test_saturation();
    idle_inputs();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL clr_flush_cnt got %0d exp 0", flush_cnt); end
    ex_wb_en = 1'b1; ex_dest = 4'd1; src1 = 4'd1; one_src = 1'b1;
    repeat ((1 << CNT_W) + 5) @(posedge clk);
    #1;
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_stall_cnt got %0h exp ffff", stall_cnt); end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL clr_over_inc got %0d exp 0", stall_cnt); end
    step();
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL inc_after_clr got %0d exp 1", stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    idle_inputs();
    mem_req = 1'b1;
    step();
    mem_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({mem_stall, freeze_if, freeze_mem} !== 3'b000) begin errors++; $display("FAIL rst_mid_wait got %b exp 000", {mem_stall, freeze_if, freeze_mem}); end
    checks++; if ({stall_cnt, flush_cnt} !== 32'd0) begin errors++; $display("FAIL rst_mid_wait_cnt got %0h exp 0", {stall_cnt, flush_cnt}); end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_back_idle got %b exp 0", mem_stall); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_mem_wait();
    test_back_to_back();
    test_load_use();
    test_raw_nofwd();
    test_branch();
    test_branch_in_wait();
    test_saturation();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
